arbitro_botones: RTL and testbench
==================================

ARBITRO_BOTONES -- requirements
Module: arbitro_botones

Interface
REQ-001 Parameter COOLDOWN_CYC, default 10: idle cycles enforced after each command completes, range 1..255.
REQ-002 Parameter ACK_TIMEOUT, default 16: cycles cmd_valid is held without cmd_ack before the command is abandoned, range 1..255.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_tmp  input  1  reset, asynchronous, active-high.
REQ-005 req_energia  input  1  debounced energy button level.
REQ-006 req_medicina  input  1  debounced medicine button level.
REQ-007 req_test  input  1  debounced test button level.
REQ-008 cmd_ack  input  1  pet state machine accepts the current command.
REQ-009 cmd_valid  output  1  a command is offered on cmd_code.
REQ-010 cmd_code  output  2  command code: 00 none, 01 energia, 10 medicina, 11 test.
REQ-011 pending  output  3  latched requests: bit0 energia, bit1 medicina, bit2 test.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 timeout_err  output  1  one-cycle pulse when a command is abandoned.
REQ-014 modo_test  output  1  test-mode flag that toggles on each acknowledged test command.

Function
REQ-015 Each request input shall be registered once, and a rising edge is detected as current=1 with previous-sample=0; levels held high shall produce no further events.
REQ-016 An edge detected in cycle N shall set the matching pending bit at the clock edge ending cycle N.
REQ-017 An edge on a source whose pending bit is already set shall be dropped, with no counting and no error.
REQ-018 States shall be IDLE, WAIT_ACK and COOLDOWN, with a 2-bit encoding.
REQ-019 IDLE with pending != 0: go to WAIT_ACK next cycle, and on that same edge load cmd_code per REQ-020, clear the granted pending bit, set cmd_valid=1 and clear the timeout counter.
REQ-020 Fixed priority: test > medicina > energia; only one grant per transition.
REQ-021 Latency: the request edge is sampled in cycle N, pending is visible in N+1, and cmd_valid is visible in N+2 when starting from IDLE.
REQ-022 WAIT_ACK: cmd_valid and cmd_code shall stay stable until cmd_ack=1 is sampled or the timeout expires.
REQ-023 WAIT_ACK with cmd_ack=1: next cycle cmd_valid=0, cmd_code=00, state COOLDOWN; if the code was 11, modo_test toggles on the same edge.
REQ-024 WAIT_ACK without ack for ACK_TIMEOUT consecutive cycles: next cycle cmd_valid=0, cmd_code=00, timeout_err=1 for exactly one cycle, state COOLDOWN, and modo_test unchanged.
REQ-025 If cmd_ack=1 arrives in the same cycle the timeout count reaches ACK_TIMEOUT, the ack shall win and no timeout_err is raised.
REQ-026 cmd_ack sampled while in IDLE or COOLDOWN shall be ignored.
REQ-027 COOLDOWN shall last exactly COOLDOWN_CYC cycles and then return to IDLE; pending bits keep accumulating during it.
REQ-028 A new edge on the source whose bit is being cleared by a grant in the same cycle shall leave that bit set (set wins).
REQ-029 Edges on several sources in the same cycle shall all latch; they are then served one by one in priority order, each followed by its own cooldown.
REQ-030 Counters shall be 8 bits wide, saturate, and never wrap.

Reset
REQ-031 While reset_tmp=1, the block shall force the following state: IDLE, cmd_valid=0, cmd_code=00, pending=000, busy=0, timeout_err=0, modo_test=0, counters=0, edge registers=0.
REQ-032 Reset asserted mid-command shall abandon the command immediately, with no timeout_err and no modo_test toggle.
REQ-033 After reset is released, a request input already high shall not count as an edge until it goes low and then high again.

Verification
REQ-034 Single energia press, cmd_ack 3 cycles after cmd_valid: cmd_valid rises 2 cycles after the edge with code 01; cmd_valid=0 after ack; busy stays high 10 more cycles.
REQ-035 Energia, medicina and test rise in the same cycle, ack given immediately each time: codes issued 11, 10, 01 in that order, each separated by 10 cooldown cycles; modo_test ends at 1.
REQ-036 Medicina press with cmd_ack never asserted: cmd_valid stays high for 16 cycles, then timeout_err pulses once, then COOLDOWN, then IDLE; pending=000.
REQ-037 Two energia edges while WAIT_ACK is already serving energia: pending[0]=1 once, one extra 01 command issued afterwards, not two.
REQ-038 reset_tmp pulsed during WAIT_ACK of a test command: all outputs are 0 asynchronously and modo_test is unchanged from 0; a held req_test produces no command after release.

Source files
------------

// File: rtl/arbitro_botones.sv
// Button request arbiter: latches debounced button edges and offers them one at a
// time to the pet state machine, with ack timeout and post-command cooldown.
module arbitro_botones #(
   parameter int COOLDOWN_CYC = 10,
   parameter int ACK_TIMEOUT  = 16
) (
   input  logic       clk,
   input  logic       reset_tmp,
   input  logic       req_energia,
   input  logic       req_medicina,
   input  logic       req_test,
   input  logic       cmd_ack,
   output logic       cmd_valid,
   output logic [1:0] cmd_code,
   output logic [2:0] pending,
   output logic       busy,
   output logic       timeout_err,
   output logic       modo_test
);

   // state      | meaning
   // S_IDLE     | no command offered; grants highest pending request
   // S_WAIT_ACK | command offered on cmd_code, waiting for cmd_ack or timeout
   // S_COOLDOWN | enforced idle gap after a command ends
   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_WAIT_ACK = 2'b01,
      S_COOLDOWN = 2'b10
   } state_t;

   localparam logic [7:0] CD_LOAD  = 8'(COOLDOWN_CYC - 1);
   localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [2:0] req_q, req_d;
   logic [2:0] arm_q, arm_d;
   logic [2:0] pend_q, pend_d;
   logic [1:0] code_q, code_d;
   logic [7:0] tmo_q, tmo_d;
   logic [7:0] cd_q, cd_d;
   logic       terr_q, terr_d;
   logic       modo_q, modo_d;

   logic [2:0] req_now;
   logic [2:0] edge_w;
   logic [2:0] grant;

   assign req_now = {req_test, req_medicina, req_energia};

   always_ff @(posedge clk or posedge reset_tmp) begin
      if (reset_tmp) begin
         state_q <= S_IDLE;
         req_q   <= 3'b000;
         arm_q   <= 3'b000;
         pend_q  <= 3'b000;
         code_q  <= 2'b00;
         tmo_q   <= 8'd0;
         cd_q    <= 8'd0;
         terr_q  <= 1'b0;
         modo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         arm_q   <= arm_d;
         pend_q  <= pend_d;
         code_q  <= code_d;
         tmo_q   <= tmo_d;
         cd_q    <= cd_d;
         terr_q  <= terr_d;
         modo_q  <= modo_d;
      end
   end

   always_comb begin
      req_d   = req_now;
      // a source only arms after it has been seen low, so a level held through reset is not an edge
      arm_d   = arm_q | ~req_now;
      edge_w  = req_now & ~req_q & arm_q;
      state_d = state_q;
      code_d  = code_q;
      tmo_d   = tmo_q;
      cd_d    = cd_q;
      terr_d  = 1'b0;
      modo_d  = modo_q;
      grant   = 3'b000;
      case (state_q)
         S_IDLE: begin
            code_d = 2'b00;
            if (pend_q != 3'b000) begin
               state_d = S_WAIT_ACK;
               tmo_d   = 8'd0;
               if (pend_q[2]) begin
                  code_d = 2'b11;
                  grant  = 3'b100;
               end else if (pend_q[1]) begin
                  code_d = 2'b10;
                  grant  = 3'b010;
               end else begin
                  code_d = 2'b01;
                  grant  = 3'b001;
               end
            end
         end
         S_WAIT_ACK: begin
            if (cmd_ack) begin
               state_d = S_COOLDOWN;
               code_d  = 2'b00;
               cd_d    = CD_LOAD;
               if (code_q == 2'b11) modo_d = ~modo_q;
            end else if (tmo_q >= TMO_LAST) begin
               state_d = S_COOLDOWN;
               code_d  = 2'b00;
               cd_d    = CD_LOAD;
               terr_d  = 1'b1;
            end else if (tmo_q != 8'hFF) begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_COOLDOWN: begin
            if (cd_q == 8'd0) state_d = S_IDLE;
            else              cd_d    = cd_q - 8'd1;
         end
         default: begin
            state_d = S_IDLE;
            code_d  = 2'b00;
         end
      endcase
      // a new edge on the source being granted this cycle keeps its bit set
      pend_d = (pend_q & ~grant) | edge_w;
   end

   always_comb begin
      cmd_valid   = (state_q == S_WAIT_ACK);
      cmd_code    = code_q;
      pending     = pend_q;
      busy        = (state_q != S_IDLE);
      timeout_err = terr_q;
      modo_test   = modo_q;
   end

endmodule

// File: tb/tb_arbitro_botones.sv
// Scoreboard bench for arbitro_botones: a timestamp-based model predicts each
// offered command and how it ends; a negedge monitor compares the DUT against it.
module tb_arbitro_botones;

   localparam int COOLDOWN = 10;
   localparam int ACK_TO   = 16;

   logic       clk = 1'b0;
   logic       reset_tmp = 1'b1;
   logic       req_energia = 1'b0;
   logic       req_medicina = 1'b0;
   logic       req_test = 1'b0;
   logic       cmd_ack = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd_code;
   logic [2:0] pending;
   logic       busy;
   logic       timeout_err;
   logic       modo_test;

   arbitro_botones #(.COOLDOWN_CYC(COOLDOWN), .ACK_TIMEOUT(ACK_TO)) dut (
      .clk         (clk),
      .reset_tmp   (reset_tmp),
      .req_energia (req_energia),
      .req_medicina(req_medicina),
      .req_test    (req_test),
      .cmd_ack     (cmd_ack),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .pending     (pending),
      .busy        (busy),
      .timeout_err (timeout_err),
      .modo_test   (modo_test)
   );

   always #5 clk = ~clk;

   typedef struct { int code; int cyc; } cmd_t;
   typedef struct { int cyc; bit to; bit modo; } end_t;

   cmd_t sq[$];
   end_t cq[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // model: pending set, current offer (code 0 = none) and first free cycle
   logic [2:0] m_pend = 0, m_prev = 0, m_arm = 0;
   int  m_code = 0, m_start = 0, m_free = 0, m_delay = 0;
   bit  m_modo = 0;
   int  ack_pol = -1;
   bit  spur = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_prev = 0; m_arm = 0;
      m_code = 0; m_start = 0; m_free = 0; m_delay = 0; m_modo = 0;
      sq.delete();
      cq.delete();
   endtask

   task automatic model_update(input logic [2:0] r, input logic ack, input int c);
      logic [2:0] e;
      e = r & ~m_prev & m_arm;
      if (m_code != 0) begin
         if (ack) begin
            if (m_code == 3) m_modo = !m_modo;
            cq.push_back('{c + 1, 1'b0, m_modo});
            m_code = 0;
            m_free = c + 1 + COOLDOWN;
         end else if (c - m_start + 1 == ACK_TO) begin
            cq.push_back('{c + 1, 1'b1, m_modo});
            m_code = 0;
            m_free = c + 1 + COOLDOWN;
         end
      end else if (c >= m_free && m_pend != 0) begin
         m_code = m_pend[2] ? 3 : (m_pend[1] ? 2 : 1);
         m_pend[m_code-1] = 1'b0;
         m_start = c + 1;
         m_delay = (ack_pol < 0) ? int'($urandom_range(0, ACK_TO + 2)) : ack_pol;
         sq.push_back('{m_code, c + 1});
      end
      m_pend = m_pend | e;
      m_arm  = m_arm | ~r;
      m_prev = r;
   endtask

   task automatic step(input logic [2:0] r, input logic rst);
      @(negedge clk);
      reset_tmp = rst;
      {req_test, req_medicina, req_energia} = r;
      if (m_code != 0) cmd_ack = ((cyc - m_start) == m_delay);
      else             cmd_ack = spur && ($urandom_range(0, 3) == 0);
      @(posedge clk);
      if (reset_tmp) model_reset();
      else           model_update(r, cmd_ack, cyc);
      cyc++;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(3'b000, 1'b0);
   endtask

   logic       mv_prev = 1'b0;
   logic [1:0] held_code = 2'b00;

   always @(negedge clk) begin
      cmd_t e;
      end_t d;
      #1;
      if (reset_tmp) begin
         chk("reset_outputs", {23'd0, cmd_valid, cmd_code, pending, busy, timeout_err, modo_test}, 0);
         mv_prev = 1'b0;
      end else begin
         chk("pending", pending, m_pend);
         chk("busy", busy, ((m_code != 0) || (cyc < m_free)) ? 1 : 0);
         chk("modo_test", modo_test, m_modo);
         if (cmd_valid && !mv_prev) begin
            if (sq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_cmd: got code %0d, expected no command (cycle %0d)", cmd_code, cyc);
            end else begin
               e = sq.pop_front();
               chk("cmd_code", cmd_code, e.code);
               chk("cmd_start_cycle", cyc, e.cyc);
            end
            held_code = cmd_code;
         end else if (cmd_valid) begin
            chk("cmd_code_stable", cmd_code, held_code);
         end else begin
            chk("cmd_code_idle", cmd_code, 0);
         end
         if (!cmd_valid && mv_prev) begin
            if (cq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_end: got end of command, expected none (cycle %0d)", cyc);
            end else begin
               d = cq.pop_front();
               chk("cmd_end_cycle", cyc, d.cyc);
               chk("timeout_err_at_end", timeout_err, d.to);
               chk("modo_at_end", modo_test, d.modo);
            end
         end else begin
            chk("timeout_err_quiet", timeout_err, 0);
         end
         mv_prev = cmd_valid;
      end
   end

   initial begin
      logic [2:0] rr;
      bit drained;
      rr = 3'b000;
      model_reset();
      for (int i = 0; i < 3; i++) step(3'b000, 1'b1);
      idle_steps(3);

      // single energia, ack 3 cycles after valid
      ack_pol = 3;
      step(3'b001, 1'b0);
      idle_steps(25);

      // all three together, immediate ack
      ack_pol = 0;
      step(3'b111, 1'b0);
      idle_steps(60);
      chk("modo_after_triple", modo_test, 1);

      // medicina, never acked
      ack_pol = 255;
      step(3'b010, 1'b0);
      idle_steps(35);
      chk("pending_after_timeout", pending, 0);

      // two energia edges while energia is being served
      ack_pol = 10;
      step(3'b001, 1'b0);
      idle_steps(3);
      step(3'b001, 1'b0);
      step(3'b000, 1'b0);
      step(3'b001, 1'b0);
      idle_steps(50);

      // ack in the last cycle before timeout
      ack_pol = ACK_TO - 1;
      step(3'b001, 1'b0);
      idle_steps(40);

      // new energia edge in the very cycle energia gets granted
      ack_pol = 0;
      step(3'b100, 1'b0);
      idle_steps(4);
      step(3'b001, 1'b0);
      idle_steps(7);
      step(3'b001, 1'b0);
      idle_steps(40);

      // randomized traffic with spurious acks
      ack_pol = -1;
      spur = 1;
      for (int i = 0; i < 2500; i++) begin
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
         step(rr, 1'b0);
      end
      spur = 0;
      ack_pol = 0;
      idle_steps(60);

      // async reset during WAIT_ACK of a test command, req_test held
      ack_pol = 255;
      for (int i = 0; i < 12; i++) begin
         step(3'b100, 1'b0);
         if (m_code == 3 && cyc - m_start >= 3) break;
      end
      chk("rst_cmd_valid_before", cmd_valid, 1);
      @(negedge clk);
      #2 reset_tmp = 1'b1;
      #1;
      chk("rst_async_outputs", {cmd_valid, cmd_code, pending, busy, timeout_err}, 0);
      chk("rst_modo", modo_test, 0);
      model_reset();
      step(3'b100, 1'b1);
      step(3'b100, 1'b1);
      for (int i = 0; i < 30; i++) step(3'b100, 1'b0);
      chk("rst_held_no_cmd", cmd_valid, 0);
      chk("rst_held_no_pending", pending, 0);
      ack_pol = -1;
      idle_steps(2);
      step(3'b100, 1'b0);
      idle_steps(5);

      // drain
      ack_pol = 0;
      drained = 0;
      for (int i = 0; i < 400; i++) begin
         step(3'b000, 1'b0);
         if (m_code == 0 && m_pend == 0 && cyc > m_free) begin
            drained = 1;
            break;
         end
      end
      idle_steps(3);
      chk("drain_done", drained, 1);
      chk("cmd_queue_empty", sq.size(), 0);
      chk("end_queue_empty", cq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
